// File: rtl/drone_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | drone_pkg : types and constants shared by the drone control stages   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package drone_pkg;

  typedef logic signed [15:0] rpm_t;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2
  } arm_state_t;

  // Per-edge duty command broadcast from the arming FSM to every channel
  typedef enum logic [1:0] {
    DUTY_HOLD = 2'd0,
    DUTY_ZERO = 2'd1,
    DUTY_IDLE = 2'd2,
    DUTY_SLEW = 2'd3
  } duty_cmd_t;

  localparam int MOT_L  = 0;
  localparam int MOT_R  = 1;
  localparam int MOT_F  = 2;
  localparam int MOT_RV = 3;

  function automatic logic signed [16:0] clamp_sym(input logic signed [16:0] v,
                                                   input logic signed [16:0] lim);
    if (v > lim) begin
      return lim;
    end else if (v < -lim) begin
      return -lim;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motpwm_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | motpwm_chan : one motor channel - target clamp, slewed duty, compare |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module motpwm_chan
  import drone_pkg::*;
#(
  parameter int PERIOD    = 1000,
  parameter int IDLE_DUTY = 50,
  parameter int SLEW_MAX  = 20,
  parameter int CW        = $clog2(PERIOD)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            boundary_i,
  input  duty_cmd_t       cmd_i,
  input  logic            run_i,
  input  logic [CW-1:0]   cnt_i,
  input  rpm_t            mot_set_i,
  output logic            pwm_o,
  output logic            sat_o
);

  localparam logic signed [16:0] c_FULL = 17'(PERIOD);
  localparam logic signed [16:0] c_IDLE = 17'(IDLE_DUTY);
  localparam logic signed [16:0] c_SLEW = 17'(SLEW_MAX);

  logic signed [16:0] duty_q, duty_d;
  logic               sat_q, sat_d;
  logic               pwm_q, pwm_d;
  logic signed [16:0] w_set;
  logic signed [16:0] w_tgt;
  logic               w_clip;
  logic signed [16:0] w_step;

  always_comb begin
    w_set  = {mot_set_i[15], mot_set_i};
    w_tgt  = w_set;
    w_clip = 1'b0;
    if (w_set < 0) begin
      w_tgt  = '0;
      w_clip = 1'b1;
    end else if (w_set > c_FULL) begin
      w_tgt  = c_FULL;
      w_clip = 1'b1;
    end
    w_step = clamp_sym(w_tgt - duty_q, c_SLEW);
  end

  // cnt_i is the counter value of the coming cycle, so the pulse lines up with cnt
  always_comb begin
    duty_d = duty_q;
    sat_d  = sat_q;
    if (boundary_i) begin
      sat_d = w_clip;
    end
    unique case (cmd_i)
      DUTY_ZERO: duty_d = '0;
      DUTY_IDLE: duty_d = c_IDLE;
      DUTY_SLEW: duty_d = duty_q + w_step;
      default:   duty_d = duty_q;
    endcase
    pwm_d = run_i && ($signed(17'(cnt_i)) < duty_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      duty_q <= '0;
      sat_q  <= 1'b0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      sat_q  <= sat_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
  assign sat_o = sat_q;

endmodule
`default_nettype wire

// File: rtl/motpwm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | motpwm   : four-channel ESC PWM driver with arming and slew limiting |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module motpwm
  import drone_pkg::*;
#(
  parameter int PERIOD      = 1000,
  parameter int IDLE_DUTY   = 50,
  parameter int ARM_PERIODS = 8,
  parameter int SLEW_MAX    = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       arm,
  input  rpm_t       mot_set [4],
  output logic [3:0] pwm_out,
  output logic       armed,
  output logic [3:0] sat,
  output logic       period_start
);

  localparam int CW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int ACW = $clog2(ARM_PERIODS + 1);
  localparam logic [CW-1:0]  c_LAST     = CW'(PERIOD - 1);
  localparam logic [ACW-1:0] c_ARM_LAST = ACW'(ARM_PERIODS - 1);

  arm_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [ACW-1:0] arm_cnt_q, arm_cnt_d;
  logic           period_start_q;
  logic           armed_q;
  logic           w_boundary;
  logic           w_run;
  duty_cmd_t      w_cmd;

  assign w_boundary = (cnt_q == c_LAST);
  assign cnt_d      = w_boundary ? '0 : cnt_q + CW'(1);
  assign w_run      = (state_d != DISARMED);

  // Disarm acts on any edge; every other transition waits for the period boundary
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    w_cmd     = DUTY_HOLD;
    if (!arm) begin
      state_d = DISARMED;
      w_cmd   = DUTY_ZERO;
    end else if (w_boundary) begin
      unique case (state_q)
        DISARMED: begin
          state_d   = ARMING;
          arm_cnt_d = '0;
          w_cmd     = DUTY_IDLE;
        end
        ARMING: begin
          if (arm_cnt_q == c_ARM_LAST) begin
            state_d = ARMED;
            w_cmd   = DUTY_SLEW;
          end else begin
            arm_cnt_d = arm_cnt_q + ACW'(1);
          end
        end
        ARMED:   w_cmd = DUTY_SLEW;
        default: begin
          state_d = DISARMED;
          w_cmd   = DUTY_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= DISARMED;
      cnt_q          <= '0;
      arm_cnt_q      <= '0;
      period_start_q <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      arm_cnt_q      <= arm_cnt_d;
      period_start_q <= (cnt_d == '0);
      armed_q        <= (state_d == ARMED);
    end
  end

  assign period_start = period_start_q;
  assign armed        = armed_q;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    motpwm_chan #(
      .PERIOD   (PERIOD),
      .IDLE_DUTY(IDLE_DUTY),
      .SLEW_MAX (SLEW_MAX),
      .CW       (CW)
    ) u_chan (
      .clk       (clk),
      .resetn    (resetn),
      .boundary_i(w_boundary),
      .cmd_i     (w_cmd),
      .run_i     (w_run),
      .cnt_i     (cnt_d),
      .mot_set_i (mot_set[i]),
      .pwm_o     (pwm_out[i]),
      .sat_o     (sat[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_motpwm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_motpwm : directed scoreboard bench for the motpwm driver          |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_motpwm;
  import drone_pkg::*;

  localparam int P    = 100;
  localparam int IDLE = 10;
  localparam int ARMP = 3;
  localparam int SLEW = 20;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       arm    = 1'b0;
  rpm_t       mot_set [4];
  logic [3:0] pwm_out;
  logic       armed;
  logic [3:0] sat;
  logic       period_start;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0][7:0] duty;
    logic            armed;
    logic [3:0]      sat;
  } exp_t;

  exp_t  sb     [$];
  string sb_tag [$];

  motpwm #(
    .PERIOD     (P),
    .IDLE_DUTY  (IDLE),
    .ARM_PERIODS(ARMP),
    .SLEW_MAX   (SLEW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .arm         (arm),
    .mot_set     (mot_set),
    .pwm_out     (pwm_out),
    .armed       (armed),
    .sat         (sat),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input int d0, input int d1, input int d2,
                      input int d3, input logic a, input logic [3:0] s);
    exp_t e;
    e.duty[0] = 8'(d0);
    e.duty[1] = 8'(d1);
    e.duty[2] = 8'(d2);
    e.duty[3] = 8'(d3);
    e.armed   = a;
    e.sat     = s;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic set_all(input int v0, input int v1, input int v2, input int v3);
    mot_set[0] = rpm_t'(v0);
    mot_set[1] = rpm_t'(v1);
    mot_set[2] = rpm_t'(v2);
    mot_set[3] = rpm_t'(v3);
  endtask

  // Sync to the next period start, then measure one full period of every channel.
  // Returns at the falling edge of the boundary cycle.
  task automatic measure(input int poke_at, input int poke_v);
    exp_t  e;
    string tag;
    int    hi     [4];
    int    glitch [4];
    bit    lo     [4];
    int    to;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 0, 1);
      return;
    end
    e   = sb.pop_front();
    tag = sb_tag.pop_front();
    to  = 0;
    do begin
      @(negedge clk);
      to++;
    end while (period_start !== 1'b1 && to < 3 * P);
    check({tag, ".sync"}, int'(period_start), 1);
    check({tag, ".armed"}, int'(armed), int'(e.armed));
    check({tag, ".sat"}, int'(sat), int'(e.sat));
    for (int ch = 0; ch < 4; ch++) begin
      hi[ch] = 0;
      glitch[ch] = 0;
      lo[ch] = 1'b0;
    end
    for (int c = 0; c < P; c++) begin
      if (c > 0) @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        if (pwm_out[ch]) begin
          hi[ch]++;
          if (lo[ch]) glitch[ch]++;
        end else begin
          lo[ch] = 1'b1;
        end
      end
      if (c == poke_at) set_all(poke_v, poke_v, poke_v, poke_v);
    end
    for (int ch = 0; ch < 4; ch++) begin
      check($sformatf("%s.duty%0d", tag, ch), hi[ch], int'(e.duty[ch]));
      check($sformatf("%s.shape%0d", tag, ch), glitch[ch], 0);
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out !== 4'h0 || armed !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic arm_sequence(input string tag);
    push({tag, ".idle0"}, IDLE, IDLE, IDLE, IDLE, 1'b0, 4'h0);
    push({tag, ".idle1"}, IDLE, IDLE, IDLE, IDLE, 1'b0, 4'h0);
    push({tag, ".idle2"}, IDLE, IDLE, IDLE, IDLE, 1'b0, 4'h0);
    push({tag, ".ramp1"}, 30, 30, 30, 30, 1'b1, 4'h0);
    push({tag, ".ramp2"}, 50, 50, 50, 50, 1'b1, 4'h0);
    repeat (5) measure(-1, 0);
  endtask

  initial begin
    // Reset held with arm requested
    set_all(50, 50, 50, 50);
    arm    = 1'b1;
    resetn = 1'b0;
    repeat (5) @(negedge clk);
    check("rst.pwm", int'(pwm_out), 0);
    check("rst.armed", int'(armed), 0);
    check("rst.sat", int'(sat), 0);
    check("rst.period_start", int'(period_start), 0);
    resetn = 1'b1;
    quiet("rst.disarmed_until_boundary", 60);

    // Arm and ramp to 50, then steady
    arm_sequence("arm");
    push("steady", 50, 50, 50, 50, 1'b1, 4'h0);
    measure(-1, 0);

    // Negative setpoint clamps to 0
    mot_set[MOT_L] = -16'sd5;
    push("neg0", 30, 50, 50, 50, 1'b1, 4'h1);
    push("neg1", 10, 50, 50, 50, 1'b1, 4'h1);
    push("neg2", 0, 50, 50, 50, 1'b1, 4'h1);
    push("neg3", 0, 50, 50, 50, 1'b1, 4'h1);
    repeat (4) measure(-1, 0);

    // Over-range setpoint clamps to full scale
    mot_set[MOT_L] = 16'sd150;
    push("ovr0", 20, 50, 50, 50, 1'b1, 4'h1);
    push("ovr1", 40, 50, 50, 50, 1'b1, 4'h1);
    push("ovr2", 60, 50, 50, 50, 1'b1, 4'h1);
    push("ovr3", 80, 50, 50, 50, 1'b1, 4'h1);
    push("ovr4", 100, 50, 50, 50, 1'b1, 4'h1);
    push("ovr5", 100, 50, 50, 50, 1'b1, 4'h1);
    repeat (6) measure(-1, 0);

    mot_set[MOT_L] = 16'sd50;
    push("back0", 80, 50, 50, 50, 1'b1, 4'h0);
    push("back1", 60, 50, 50, 50, 1'b1, 4'h0);
    push("back2", 50, 50, 50, 50, 1'b1, 4'h0);
    repeat (3) measure(-1, 0);

    // Independent channels; mid-period change must not alter the running period
    set_all(0, 40, 80, 100);
    push("ind0", 30, 40, 70, 70, 1'b1, 4'h0);
    push("ind1", 10, 40, 80, 90, 1'b1, 4'h0);
    push("ind2", 0, 40, 80, 100, 1'b1, 4'h0);
    push("ind3_mid", 0, 40, 80, 100, 1'b1, 4'h0);
    repeat (3) measure(-1, 0);
    measure(60, 50);
    push("rec0", 20, 50, 60, 80, 1'b1, 4'h0);
    push("rec1", 40, 50, 50, 60, 1'b1, 4'h0);
    push("rec2", 50, 50, 50, 50, 1'b1, 4'h0);
    repeat (3) measure(-1, 0);

    // Disarm at cnt=37 takes effect on that edge
    repeat (38) @(negedge clk);
    check("dis.pre_pwm", int'(pwm_out), 15);
    arm = 1'b0;
    @(negedge clk);
    check("dis.pwm", int'(pwm_out), 0);
    check("dis.armed", int'(armed), 0);
    quiet("dis.hold", 12);
    arm = 1'b1;
    arm_sequence("rearm");

    // Asynchronous reset at cnt=20 while ARMED
    repeat (21) @(negedge clk);
    check("arst.pre_pwm", int'(pwm_out), 15);
    check("arst.pre_armed", int'(armed), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst.pwm", int'(pwm_out), 0);
    check("arst.armed", int'(armed), 0);
    check("arst.sat", int'(sat), 0);
    check("arst.period_start", int'(period_start), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    quiet("arst.disarmed_until_boundary", 60);
    arm_sequence("restart");

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
